apb_master: RTL

- APB3 requester that drives the slave end of `apb_if` (PADDR/PSEL/PENABLE/PWRITE/PWDATA out; PRDATA/PREADY/PSLVERR in).
- Converts single-beat commands from a simple valid/ready command port into APB transfers. Returns read data and error status on a valid/ready response port.
- Sits between a bench or CPU-side sequencer and any APB slave, including wait-state slaves.
- A bounded wait-state timeout prevents a hung slave from stalling the requester forever.

---
 rtl/apb_pkg.sv | 25 ++
 rtl/apb_wait_timer.sv | 40 ++++
 rtl/apb_master.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB3 requester and its wait-state timer.
package apb_pkg;

    localparam int APB_ADDR_WIDTH = 8;
    localparam int APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic [APB_DATA_WIDTH-1:0] rdata;
        logic                      err;
        logic                      timeout;
    } apb_rsp_t;

    // Counter width able to hold 0..cycles; at least one bit when the timeout is disabled.
    function automatic int timer_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter; o_expired flags that the next wait cycle hits the limit.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    localparam int CW = timer_width(TIMEOUT_CYCLES);

    logic [CW-1:0] r_count;
    logic          w_at_limit;

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign w_at_limit = 1'b1;
            assign o_expired  = 1'b0;
        end else begin : g_on
            assign w_at_limit = (r_count == CW'(TIMEOUT_CYCLES));
            // Looks one step ahead so the abort lands on the edge the count reaches the limit.
            assign o_expired  = (r_count >= CW'(TIMEOUT_CYCLES - 1));
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !w_at_limit) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/apb_master.sv
// APB3 requester: one valid/ready command in, one APB transfer out, one response back.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    apb_state_e            r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_paddr, w_paddr_next;
    logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata_next;
    logic                  r_psel, w_psel_next;
    logic                  r_penable, w_penable_next;
    logic                  r_pwrite, w_pwrite_next;
    logic                  r_rsp_valid, w_rsp_valid_next;
    logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_next;
    logic                  r_rsp_err, w_rsp_err_next;
    logic                  r_rsp_timeout, w_rsp_timeout_next;
    logic                  w_timer_clr;
    logic                  w_timer_inc;
    logic                  w_timer_expired;

    assign cmd_ready = (r_state == IDLE) && PRESET;

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .i_clk    (PCLK),
        .i_rst_n  (PRESET),
        .i_clr    (w_timer_clr),
        .i_inc    (w_timer_inc),
        .o_expired(w_timer_expired)
    );

    always_comb begin
        w_state_next       = r_state;
        w_paddr_next       = r_paddr;
        w_pwdata_next      = r_pwdata;
        w_psel_next        = r_psel;
        w_penable_next     = r_penable;
        w_pwrite_next      = r_pwrite;
        w_rsp_valid_next   = r_rsp_valid;
        w_rsp_rdata_next   = r_rsp_rdata;
        w_rsp_err_next     = r_rsp_err;
        w_rsp_timeout_next = r_rsp_timeout;
        w_timer_clr        = 1'b0;
        w_timer_inc        = (r_state == ACCESS) && !PREADY;

        case (r_state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    w_paddr_next   = cmd_addr;
                    w_pwrite_next  = cmd_write;
                    w_pwdata_next  = cmd_wdata;
                    w_psel_next    = 1'b1;
                    w_penable_next = 1'b0;
                    w_state_next   = SETUP;
                end
            end
            SETUP: begin
                w_penable_next = 1'b1;
                w_timer_clr    = 1'b1;
                w_state_next   = ACCESS;
            end
            ACCESS: begin
                // A completing PREADY takes priority over a simultaneous timeout.
                if (PREADY) begin
                    w_rsp_rdata_next   = r_pwrite ? '0 : PRDATA;
                    w_rsp_err_next     = PSLVERR;
                    w_rsp_timeout_next = 1'b0;
                    w_psel_next        = 1'b0;
                    w_penable_next     = 1'b0;
                    w_rsp_valid_next   = 1'b1;
                    w_state_next       = RESP;
                end else if (w_timer_expired) begin
                    w_rsp_rdata_next   = '0;
                    w_rsp_err_next     = 1'b1;
                    w_rsp_timeout_next = 1'b1;
                    w_psel_next        = 1'b0;
                    w_penable_next     = 1'b0;
                    w_rsp_valid_next   = 1'b1;
                    w_state_next       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_next = 1'b0;
                    w_state_next     = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_state       <= IDLE;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_paddr       <= w_paddr_next;
            r_pwdata      <= w_pwdata_next;
            r_psel        <= w_psel_next;
            r_penable     <= w_penable_next;
            r_pwrite      <= w_pwrite_next;
            r_rsp_valid   <= w_rsp_valid_next;
            r_rsp_rdata   <= w_rsp_rdata_next;
            r_rsp_err     <= w_rsp_err_next;
            r_rsp_timeout <= w_rsp_timeout_next;
        end
    end

    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;
    assign PSEL        = r_psel;
    assign PENABLE     = r_penable;
    assign PWRITE      = r_pwrite;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;

endmodule
